rx_link_supervisor: RTL and testbench
=====================================

# rx_link_supervisor

Link supervisor and output sequencer for the slave-side optical receiver. It sits downstream of the serial receive/decode block. It watches the receiver's own symbol lock, the lock flag carried inside each frame, the per-frame update strobe and SFP LOS. It sequences the link through acquire, run and fault-holdoff states, and passes the decoded drive bits {D4..D1} to the gate-drive logic only while the link is proven healthy. Any loss forces the outputs low and imposes a fixed holdoff before re-acquisition, so a flapping fibre can never chatter the bridge.

## Interface
- WDT_CYC, 90: frame watchdog in clocks; 3 frame periods at 60 MHz / 2 Mbps.
- LOCK_FRAMES, 16: consecutive good frames required in ACQUIRE before RUN.
- HOLDOFF_CYC, 60000: FAULT dwell in clocks (1 ms).
- i_clk  in  1  master clock, 60 MHz.
- i_res_n  in  1  asynchronous active-low reset.
- i_sfp_los  in  1  raw SFP LOS, asynchronous; synchronized internally by 2 FF, reset value 1.
- i_my_lock  in  1  receiver symbol-lock status, synchronous to i_clk.
- i_rx_lock  in  1  remote lock flag decoded from the frame; valid on i_frame_stb.
- i_frame_stb  in  1  one-clock pulse per accepted data frame.
- i_data  in  4  decoded {D4,D3,D2,D1}; valid on i_frame_stb.
- o_data  out  4  gated drive bits; 0 unless in RUN.
- o_gate_en  out  1  1 only in RUN.
- o_state  out  2  0 IDLE, 1 ACQUIRE, 2 RUN, 3 FAULT.
- o_fault  out  1  sticky fault flag; set on entry to FAULT, cleared by i_res_n only.
- o_fault_cnt  out  8  count of FAULT entries; saturates at 255.

## Operation
- The loss condition L is LOS_sync OR ~i_my_lock OR watchdog expired OR (i_frame_stb AND ~i_rx_lock).
- The watchdog counter clears on i_frame_stb and on any state change. Otherwise it increments, saturating at WDT_CYC. It is expired when it equals WDT_CYC. It runs only in ACQUIRE and RUN.
- IDLE:
  - outputs forced low, counters cleared.
  - go to ACQUIRE when LOS_sync=0 and i_my_lock=1.
- ACQUIRE:
  - the good-frame counter increments on each i_frame_stb with i_rx_lock=1.
  - on L, go to FAULT.
  - on the strobe that brings the count to LOCK_FRAMES, go to RUN.
  - o_data stays 0 throughout.
- RUN:
  - on each i_frame_stb with i_rx_lock=1, o_data <= i_data.
  - between strobes, o_data holds its value.
  - on L, go to FAULT; o_data and o_gate_en drop to 0 in that same transition.
- FAULT:
  - on entry, set o_fault and increment o_fault_cnt (saturating).
  - the holdoff counter runs for HOLDOFF_CYC clocks, then the block goes to IDLE.
  - L during FAULT is ignored; the holdoff is not restarted.
- Priority within one clock is L over a good strobe. A strobe carrying i_rx_lock=0 is a loss, never a data update.
- Counter widths are $clog2(param+1). All counters saturate and never wrap.

## Timing
- All outputs are registered and update on the clock edge after the condition is sampled. Only exception: LOS, which adds 2 clocks of synchronizer latency.
- Strobe-to-o_data latency in RUN is 1 clock.
- Loss detect (i_my_lock fall or bad strobe) to o_gate_en=0 and o_data=0 is 1 clock.
- Watchdog: with the last strobe at clock t, expiry is at t+WDT_CYC, and the outputs drop at t+WDT_CYC+1.
- ACQUIRE to RUN happens 1 clock after the LOCK_FRAMES-th good strobe.
- FAULT to IDLE happens HOLDOFF_CYC clocks after FAULT entry. Earliest ACQUIRE is 1 clock later.
- Reset values: o_data=0, o_gate_en=0, o_state=0, o_fault=0, o_fault_cnt=0, synchronizer=11.
- Reset asserted mid-RUN drives all outputs to their reset values immediately, without waiting for a clock.

## Test plan
- Nominal acquire:
  - stimulus: LOS=0, my_lock=1, strobe every 30 clk with rx_lock=1, data=4'hA.
  - response: ACQUIRE, then RUN 1 clk after the 16th strobe; o_data=4'hA 1 clk after the 17th strobe; o_gate_en=1.
- Watchdog:
  - stimulus: in RUN, stop strobes.
  - response: o_gate_en=0 and o_data=0 exactly 91 clk after the last strobe; o_state=3; o_fault=1; o_fault_cnt=1.
- Holdoff:
  - stimulus: toggle my_lock during FAULT.
  - response: IDLE exactly 60000 clk after FAULT entry; re-acquire needs 16 fresh good frames.
- Bad frame:
  - stimulus: in ACQUIRE at good frame 10, one strobe with rx_lock=0.
  - response: FAULT; o_data never leaves 0.
- LOS and simultaneity:
  - stimulus: LOS pulse of 1 clk in RUN, coincident with a good strobe carrying data=4'hF.
  - response: FAULT 3 clk later; o_data not updated to 4'hF past the loss.
- Reset and saturation:
  - stimulus: async reset mid-RUN; separately, force 300 faults.
  - response: reset gives all outputs 0 immediately; o_fault_cnt holds at 255.

Source files
------------

// File: rtl/rx_link_supervisor_if.sv
// Bundle of the receive-side status inputs and the gated drive outputs of the
// optical link supervisor; clock and reset stay plain ports on the module.
interface rx_link_supervisor_if;
    logic       i_sfp_los;
    logic       i_my_lock;
    logic       i_rx_lock;
    logic       i_frame_stb;
    logic [3:0] i_data;
    logic [3:0] o_data;
    logic       o_gate_en;
    logic [1:0] o_state;
    logic       o_fault;
    logic [7:0] o_fault_cnt;

    modport master (
        output i_sfp_los, i_my_lock, i_rx_lock, i_frame_stb, i_data,
        input  o_data, o_gate_en, o_state, o_fault, o_fault_cnt
    );

    modport slave (
        input  i_sfp_los, i_my_lock, i_rx_lock, i_frame_stb, i_data,
        output o_data, o_gate_en, o_state, o_fault, o_fault_cnt
    );
endinterface

// File: rtl/rx_link_supervisor.sv
// Link supervisor: sequences IDLE -> ACQUIRE -> RUN -> FAULT and only lets the
// decoded drive bits through to the gate drivers while the link is healthy.
module rx_link_supervisor #(
    parameter int WDT_CYC     = 90,
    parameter int LOCK_FRAMES = 16,
    parameter int HOLDOFF_CYC = 60000
) (
    input  logic                 i_clk,
    input  logic                 i_res_n,
    rx_link_supervisor_if.slave  link
);

    localparam int WDT_W = $clog2(WDT_CYC + 1);
    localparam int GF_W  = $clog2(LOCK_FRAMES + 1);
    localparam int HO_W  = $clog2(HOLDOFF_CYC + 1);

    localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(WDT_CYC);
    localparam logic [GF_W-1:0]  GF_MAX  = GF_W'(LOCK_FRAMES);
    localparam logic [HO_W-1:0]  HO_LAST = HO_W'(HOLDOFF_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACQ   = 2'd1,
        S_RUN   = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             los_meta_q, los_sync_q;
    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic [GF_W-1:0]  gf_q, gf_d;
    logic [HO_W-1:0]  ho_q, ho_d;
    logic [3:0]       data_q, data_d;
    logic             gate_q, gate_d;
    logic             fault_q, fault_d;
    logic [7:0]       fcnt_q, fcnt_d;

    logic             loss;
    logic             good_stb;
    logic             fault_entry;

    // NOTE: the synchronizer resets to "LOS asserted" so the link is treated as
    // dark until two clean samples of the real pin have been taken.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            los_meta_q <= 1'b1;
            los_sync_q <= 1'b1;
        end else begin
            los_meta_q <= link.i_sfp_los;
            los_sync_q <= los_meta_q;
        end
    end

    // A strobe with the remote lock flag low is a loss, never a data update.
    assign loss     = los_sync_q | ~link.i_my_lock | (wdt_q == WDT_MAX)
                    | (link.i_frame_stb & ~link.i_rx_lock);
    assign good_stb = link.i_frame_stb & link.i_rx_lock;

    // NOTE: every variable gets a default before the case so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        gf_d    = '0;
        ho_d    = '0;
        data_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (!los_sync_q && link.i_my_lock) state_d = S_ACQ;
            end
            S_ACQ: begin
                gf_d = gf_q;
                if (loss) begin
                    state_d = S_FAULT;
                end else if (good_stb) begin
                    if (gf_q != GF_MAX) gf_d = gf_q + 1'b1;
                    if (gf_d == GF_MAX) state_d = S_RUN;
                end
            end
            S_RUN: begin
                data_d = data_q;
                if (loss) begin
                    state_d = S_FAULT;
                    data_d  = '0;
                end else if (good_stb) begin
                    data_d = link.i_data;
                end
            end
            S_FAULT: begin
                // Loss is ignored here: the holdoff always runs to completion.
                if (ho_q == HO_LAST) state_d = S_IDLE;
                else                 ho_d    = ho_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_d != state_q) || link.i_frame_stb ||
            !(state_q inside {S_ACQ, S_RUN}))
            wdt_d = '0;
        else if (wdt_q != WDT_MAX)
            wdt_d = wdt_q + 1'b1;
        else
            wdt_d = wdt_q;

        gate_d      = (state_d == S_RUN);
        fault_entry = (state_d == S_FAULT) && (state_q != S_FAULT);
        fault_d     = fault_q | fault_entry;
        fcnt_d      = (fault_entry && fcnt_q != 8'hFF) ? fcnt_q + 8'd1 : fcnt_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            state_q <= S_IDLE;
            wdt_q   <= '0;
            gf_q    <= '0;
            ho_q    <= '0;
            data_q  <= '0;
            gate_q  <= 1'b0;
            fault_q <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wdt_q   <= wdt_d;
            gf_q    <= gf_d;
            ho_q    <= ho_d;
            data_q  <= data_d;
            gate_q  <= gate_d;
            fault_q <= fault_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign link.o_data      = data_q;
    assign link.o_gate_en   = gate_q;
    assign link.o_state     = state_q;
    assign link.o_fault     = fault_q;
    assign link.o_fault_cnt = fcnt_q;

endmodule

// File: tb/tb_rx_link_supervisor.sv
// Directed bench for rx_link_supervisor: expectations are queued with the clock
// at which they fall due and are checked by a monitor on the falling edge.
module tb_rx_link_supervisor;

    localparam int WDT  = 90;
    localparam int LOCK = 16;
    localparam int HOLD = 64;

    typedef enum int {F_DATA, F_GATE, F_STATE, F_FAULT, F_FCNT} field_e;
    typedef struct {
        int         due;
        field_e     fld;
        logic [7:0] val;
        string      tag;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   passes;
    exp_t sb[$];

    rx_link_supervisor_if link_if();

    rx_link_supervisor #(
        .WDT_CYC    (WDT),
        .LOCK_FRAMES(LOCK),
        .HOLDOFF_CYC(HOLD)
    ) dut (
        .i_clk  (clk),
        .i_res_n(rst_n),
        .link   (link_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic logic [7:0] observe(input field_e f);
        case (f)
            F_DATA:  return {4'b0, link_if.o_data};
            F_GATE:  return {7'b0, link_if.o_gate_en};
            F_STATE: return {6'b0, link_if.o_state};
            F_FAULT: return {7'b0, link_if.o_fault};
            default: return link_if.o_fault_cnt;
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                check(sb[i].tag, observe(sb[i].fld), sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(input int due, input field_e f, input logic [7:0] v, input string tag);
        exp_t e;
        e.due = due;
        e.fld = f;
        e.val = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic pulse(input logic rx, input logic [3:0] d);
        link_if.i_frame_stb = 1'b1;
        link_if.i_rx_lock   = rx;
        link_if.i_data      = d;
        step();
        link_if.i_frame_stb = 1'b0;
        link_if.i_rx_lock   = 1'b0;
    endtask

    task automatic acquire16(input logic [3:0] d);
        int t;
        for (int k = 1; k <= LOCK; k++) begin
            idle(29);
            t = cyc + 1;
            if (k == LOCK - 1) expect_at(t, F_STATE, 8'd1, "acq_not_early");
            if (k == LOCK) begin
                expect_at(t - 1, F_STATE, 8'd1, "acq_before_last");
                expect_at(t,     F_STATE, 8'd2, "acq_to_run");
                expect_at(t,     F_GATE,  8'd1, "run_gate_on");
                expect_at(t,     F_DATA,  8'd0, "run_entry_data");
            end
            pulse(1'b1, d);
        end
    endtask

    task automatic direct_reset_checks(input string tag);
        check({tag, "_data"},  observe(F_DATA),  8'd0);
        check({tag, "_gate"},  observe(F_GATE),  8'd0);
        check({tag, "_state"}, observe(F_STATE), 8'd0);
        check({tag, "_fault"}, observe(F_FAULT), 8'd0);
        check({tag, "_fcnt"},  observe(F_FCNT),  8'd0);
    endtask

    initial begin
        int t;
        int f;
        checks = 0;
        passes = 0;
        rst_n  = 1'b0;
        link_if.i_sfp_los   = 1'b1;
        link_if.i_my_lock   = 1'b0;
        link_if.i_rx_lock   = 1'b0;
        link_if.i_frame_stb = 1'b0;
        link_if.i_data      = 4'h0;

        // Power-on reset values.
        #3;
        direct_reset_checks("por");
        idle(2);
        rst_n = 1'b1;

        // LOS clears through the 2-FF synchronizer, then ACQUIRE.
        link_if.i_sfp_los = 1'b0;
        link_if.i_my_lock = 1'b1;
        expect_at(cyc + 2, F_STATE, 8'd0, "los_sync_latency");
        expect_at(cyc + 3, F_STATE, 8'd1, "idle_to_acq");

        // Nominal acquire: RUN after 16th strobe, data on 17th.
        acquire16(4'hA);
        idle(29);
        t = cyc + 1;
        expect_at(t - 1, F_DATA, 8'h0, "data_before_17th");
        expect_at(t,     F_DATA, 8'hA, "data_17th");
        pulse(1'b1, 4'hA);

        // New data pattern, hold between strobes, then watchdog.
        idle(29);
        t = cyc + 1;
        expect_at(t,          F_DATA,  8'h5, "run_update_5");
        expect_at(t + 20,     F_DATA,  8'h5, "run_hold_5");
        expect_at(t + WDT,    F_STATE, 8'd2, "wdt_not_yet");
        expect_at(t + WDT,    F_GATE,  8'd1, "wdt_gate_still_on");
        expect_at(t + WDT,    F_FAULT, 8'd0, "fault_clear_before");
        expect_at(t + WDT + 1, F_STATE, 8'd3, "wdt_fault_state");
        expect_at(t + WDT + 1, F_GATE,  8'd0, "wdt_gate_off");
        expect_at(t + WDT + 1, F_DATA,  8'd0, "wdt_data_off");
        expect_at(t + WDT + 1, F_FAULT, 8'd1, "wdt_fault_flag");
        expect_at(t + WDT + 1, F_FCNT,  8'd1, "wdt_fault_cnt");
        pulse(1'b1, 4'h5);
        f = t + WDT + 1;

        // Holdoff: my_lock chatter during FAULT must not restart it.
        expect_at(f + HOLD - 1, F_STATE, 8'd3, "holdoff_still_fault");
        expect_at(f + HOLD,     F_STATE, 8'd0, "holdoff_to_idle");
        expect_at(f + HOLD,     F_FCNT,  8'd1, "holdoff_no_reentry");
        expect_at(f + HOLD + 1, F_STATE, 8'd1, "holdoff_reacquire");
        wait_until(f);
        while (cyc < f + 40) begin
            link_if.i_my_lock = ~link_if.i_my_lock;
            step();
        end
        link_if.i_my_lock = 1'b1;
        wait_until(f + HOLD + 1);

        // Bad frame as the 10th strobe in ACQUIRE.
        for (int k = 1; k <= 10; k++) begin
            idle(29);
            t = cyc + 1;
            expect_at(t, F_DATA, 8'd0, "acq_data_zero");
            if (k == 10) begin
                expect_at(t - 1, F_STATE, 8'd1, "bad_before");
                expect_at(t,     F_STATE, 8'd3, "bad_frame_fault");
                expect_at(t,     F_GATE,  8'd0, "bad_frame_gate");
                expect_at(t,     F_FCNT,  8'd2, "bad_frame_cnt");
                expect_at(t + 1, F_DATA,  8'd0, "bad_frame_data");
                pulse(1'b0, 4'hB);
            end else begin
                pulse(1'b1, 4'hB);
            end
        end
        f = t;
        expect_at(f + HOLD + 1, F_STATE, 8'd1, "bad_reacquire");
        wait_until(f + HOLD + 1);

        // Re-acquire needs 16 fresh frames; then LOS pulse with a good strobe.
        acquire16(4'h3);
        idle(29);
        t = cyc + 1;
        expect_at(t, F_DATA, 8'h6, "run_update_6");
        pulse(1'b1, 4'h6);
        idle(29);
        t = cyc + 1;
        expect_at(t + 1, F_STATE, 8'd2, "los_not_yet");
        expect_at(t + 2, F_STATE, 8'd3, "los_fault");
        expect_at(t + 2, F_DATA,  8'd0, "los_data_off");
        expect_at(t + 2, F_GATE,  8'd0, "los_gate_off");
        expect_at(t + 2, F_FCNT,  8'd3, "los_fault_cnt");
        expect_at(t + 6, F_DATA,  8'd0, "los_data_stays_0");
        link_if.i_sfp_los = 1'b1;
        pulse(1'b1, 4'hF);
        link_if.i_sfp_los = 1'b0;
        f = t + 2;
        expect_at(f + HOLD, F_STATE, 8'd0, "los_holdoff_idle");
        wait_until(f + HOLD + 1);

        // Loss beats a good strobe in the same clock.
        acquire16(4'h8);
        idle(29);
        t = cyc + 1;
        expect_at(t, F_DATA, 8'h9, "run_update_9");
        pulse(1'b1, 4'h9);
        idle(29);
        t = cyc + 1;
        expect_at(t, F_STATE, 8'd3, "prio_fault");
        expect_at(t, F_DATA,  8'd0, "prio_data_not_c");
        expect_at(t, F_GATE,  8'd0, "prio_gate_off");
        expect_at(t, F_FCNT,  8'd4, "prio_fault_cnt");
        link_if.i_my_lock = 1'b0;
        pulse(1'b1, 4'hC);
        link_if.i_my_lock = 1'b1;
        f = t;
        wait_until(f + HOLD + 1);

        // Asynchronous reset mid-RUN.
        acquire16(4'h1);
        idle(29);
        t = cyc + 1;
        expect_at(t, F_DATA, 8'h7, "run_update_7");
        pulse(1'b1, 4'h7);
        idle(5);
        #3;
        rst_n = 1'b0;
        #1;
        direct_reset_checks("async_rst");
        idle(2);
        rst_n = 1'b1;

        // Fault counter saturation over 300 fault entries.
        link_if.i_my_lock = 1'b0;
        idle(3);
        for (int i = 1; i <= 300; i++) begin
            link_if.i_my_lock = 1'b1;
            step();
            link_if.i_my_lock = 1'b0;
            t = cyc + 1;
            if (i == 1)   expect_at(t, F_FCNT, 8'd1,   "sat_first");
            if (i == 254) expect_at(t, F_FCNT, 8'd254, "sat_254");
            if (i == 255) expect_at(t, F_FCNT, 8'd255, "sat_255");
            if (i == 256) expect_at(t, F_FCNT, 8'd255, "sat_256");
            if (i == 300) begin
                expect_at(t, F_FCNT,  8'd255, "sat_300");
                expect_at(t, F_FAULT, 8'd1,   "sat_fault_flag");
            end
            step();
            link_if.i_my_lock = 1'b1;
            idle(HOLD);
        end

        // Drain any outstanding expectations within a bounded window.
        for (int n = 0; n < 200 && sb.size() > 0; n++) step();
        while (sb.size() > 0) begin
            checks++;
            $error("FAIL %s: observed none expected %0h (never reached)", sb[0].tag, sb[0].val);
            void'(sb.pop_front());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
